// File: rtl/fm_pkg.sv
// Shared types and widths for the FM operator phase pipeline.
// Imported by the phase sequencer and its key-on pending mask.
package fm_pkg;

  localparam int PHASE_W = 19;
  localparam int OPIDX_W = 6;
  localparam int MAX_OPS = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/fm_keyon_pending.sv
// Per-operator key-on pending mask: set wins over clear on the same op.
// pend is captured for the op being read so the following write can use it.
module fm_keyon_pending
  import fm_pkg::*;
#(
  parameter int NUM_OPS = 36
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               set_en,
  input  logic [OPIDX_W-1:0] set_idx,
  input  logic               clr_en,
  input  logic [OPIDX_W-1:0] clr_idx,
  input  logic               cap_en,
  input  logic [OPIDX_W-1:0] cap_idx,
  output logic               pend
);

  logic [MAX_OPS-1:0] mask;
  logic [MAX_OPS-1:0] set_vec;
  logic [MAX_OPS-1:0] clr_vec;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set_en && (int'(set_idx) < NUM_OPS)) set_vec[set_idx] = 1'b1;
    if (clr_en) clr_vec[clr_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask <= '0;
      pend <= 1'b0;
    end else begin
      mask <= (mask & ~clr_vec) | set_vec;
      // forward a same-cycle key-on so it is not lost by the following clear
      if (cap_en) pend <= mask[cap_idx] | set_vec[cap_idx];
    end
  end

endmodule

// File: rtl/fm_phase_sequencer.sv
// Sweeps the operator phase RAM once per sample tick (read, add, write back).
// Optional debug read port enabled by defining FM_PHASE_DBG_RD_EN.
module fm_phase_sequencer #(
  parameter int NUM_OPS = 36,
  parameter int PHASE_W = fm_pkg::PHASE_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sample_tick,
  output logic [fm_pkg::OPIDX_W-1:0] op_idx,
  input  logic [PHASE_W-1:0]         phase_inc,
  input  logic                       keyon_req,
  input  logic [fm_pkg::OPIDX_W-1:0] keyon_idx,
  output logic [fm_pkg::OPIDX_W-1:0] ram_idx,
  output logic [PHASE_W-1:0]         ram_wrdata,
  output logic                       ram_wren,
  input  logic [PHASE_W-1:0]         ram_rddata,
  output logic [PHASE_W-1:0]         phase_out,
  output logic                       phase_valid,
  output logic [fm_pkg::OPIDX_W-1:0] phase_idx,
  output logic                       busy,
  output logic                       overrun,
  input  logic                       overrun_clr
`ifdef FM_PHASE_DBG_RD_EN
  ,
  input  logic                       dbg_req,
  input  logic [fm_pkg::OPIDX_W-1:0] dbg_idx,
  output logic                       dbg_ack,
  output logic [PHASE_W-1:0]         dbg_rddata
`endif
);

  import fm_pkg::*;

  localparam logic [OPIDX_W-1:0] LAST_OP = OPIDX_W'(NUM_OPS - 1);

  state_t               state;
  state_t               state_nx;
  logic [OPIDX_W-1:0]   op;
  logic [PHASE_W-1:0]   phase_q;
  logic [PHASE_W-1:0]   inc_q;
  logic [PHASE_W-1:0]   sum;
  logic                 tick_pending;
  logic                 pend_op;
  logic                 last_op;
  logic                 start;
  logic                 in_read;
  logic                 in_write;

  assign last_op  = (op == LAST_OP);
  assign in_read  = (state == ST_READ);
  assign in_write = (state == ST_WRITE);
  assign sum      = phase_q + inc_q;

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (sample_tick || tick_pending) begin
          state_nx = ST_READ;
          start    = 1'b1;
        end
      end
      ST_READ: state_nx = ST_WRITE;
      ST_WRITE: begin
        if (!last_op) begin
          state_nx = ST_READ;
        end else if (tick_pending) begin
          // back-to-back sweep, no idle gap
          state_nx = ST_READ;
          start    = 1'b1;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      op           <= '0;
      phase_q      <= '0;
      inc_q        <= '0;
      tick_pending <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state <= state_nx;
      if (start) op <= '0;
      else if (in_write && !last_op) op <= op + OPIDX_W'(1);
      if (in_read) begin
        phase_q <= ram_rddata;
        inc_q   <= phase_inc;
      end
      if (start) tick_pending <= 1'b0;
      else if (sample_tick && busy) tick_pending <= 1'b1;
      if (sample_tick && busy && tick_pending) overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

  fm_keyon_pending #(
    .NUM_OPS(NUM_OPS)
  ) u_pend (
    .clk    (clk),
    .reset  (reset),
    .set_en (keyon_req),
    .set_idx(keyon_idx),
    .clr_en (in_write),
    .clr_idx(op),
    .cap_en (in_read),
    .cap_idx(op),
    .pend   (pend_op)
  );

`ifdef FM_PHASE_DBG_RD_EN
  logic dbg_sel;

  assign dbg_sel = (state == ST_IDLE) && !sample_tick && !tick_pending
                   && dbg_req && !dbg_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      dbg_ack    <= 1'b0;
      dbg_rddata <= '0;
    end else begin
      dbg_ack <= dbg_sel;
      if (dbg_sel) dbg_rddata <= ram_rddata;
    end
  end
`endif

  always_comb begin
    busy        = (state != ST_IDLE);
    op_idx      = op;
    ram_idx     = op;
    ram_wren    = 1'b0;
    ram_wrdata  = '0;
    phase_valid = 1'b0;
    phase_out   = '0;
    phase_idx   = '0;
    if (in_write) begin
      ram_wren    = 1'b1;
      ram_wrdata  = pend_op ? '0 : sum;
      phase_valid = 1'b1;
      phase_out   = pend_op ? '0 : sum;
      phase_idx   = op;
    end
`ifdef FM_PHASE_DBG_RD_EN
    if (dbg_sel) ram_idx = dbg_idx;
`endif
  end

endmodule
